// File: rtl/wb_pkg.sv
// Shared definitions for the write-back stage: load encodings, the WB slot
// layout and the bubble constant.
package wb_pkg;

    // Load width/extension codes carried down the pipe from decode.
    // Codes 5-7 are unused and are treated as LW.
    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4
    } load_type_e;

    // One captured write-back slot, exactly what the register file sees.
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  addr;
        logic        we;
    } wb_slot_t;

    // Empty slot loaded on flush and reset.
    localparam wb_slot_t WB_BUBBLE = '{result: 32'd0, addr: 5'd0, we: 1'b0};

endpackage

// File: rtl/load_align.sv
// Combinational big-endian load alignment and sign/zero extension.
// Byte offset 0 addresses bits 31:24; a halfword with offset bit 1 clear
// addresses bits 31:16 (offset bit 0 is ignored for halfwords).
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] mem_data,
    input  logic [2:0]  load_type,
    input  logic [1:0]  byte_offset,
    output logic [31:0] value
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Pick the addressed byte/halfword and extend it according to load_type.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        sel_byte = mem_data[31:24];
        sel_half = mem_data[31:16];
        value    = mem_data;

        case (byte_offset)
            2'd0: sel_byte = mem_data[31:24];
            2'd1: sel_byte = mem_data[23:16];
            2'd2: sel_byte = mem_data[15:8];
            2'd3: sel_byte = mem_data[7:0];
            default: sel_byte = mem_data[31:24];
        endcase

        sel_half = byte_offset[1] ? mem_data[15:0] : mem_data[31:16];

        case (load_type)
            LT_LB:   value = {{24{sel_byte[7]}}, sel_byte};
            LT_LBU:  value = {24'd0, sel_byte};
            LT_LH:   value = {{16{sel_half[15]}}, sel_half};
            LT_LHU:  value = {16'd0, sel_half};
            default: value = mem_data;
        endcase
    end

endmodule

// File: rtl/write_back.sv
// Write-back pipeline stage: selects ALU or aligned load data, registers the
// register-file write for one cycle, honours stall/flush.
// Optional feature: define WB_RETIRE_COUNT_EN to add the 32-bit `retired`
// counter port (counts captured valid slots, wraps at 2^32).
module write_back
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_data,
    input  logic [4:0]  dest_addr,
    input  logic        reg_write_in,
    input  logic        mem_to_reg,
    input  logic [2:0]  load_type,
    input  logic [1:0]  byte_offset,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] write_result,
    output logic [4:0]  write_addr,
    output logic        register_write
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [31:0] retired
`endif
);

    logic [31:0] load_value;
    wb_slot_t    next_slot;
    wb_slot_t    slot_q;

    load_align u_load_align (
        .mem_data    (mem_data),
        .load_type   (load_type),
        .byte_offset (byte_offset),
        .value       (load_value)
    );

    // Build the slot the MEM stage is offering this cycle. r0 is never written.
    always_comb begin
        next_slot        = WB_BUBBLE;
        next_slot.result = mem_to_reg ? load_value : alu_result;
        next_slot.addr   = dest_addr;
        next_slot.we     = mem_valid && reg_write_in && (dest_addr != 5'd0);
    end

    // WB pipeline register: reset and flush load a bubble, stall holds.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            slot_q <= WB_BUBBLE;
        end else if (flush) begin
            slot_q <= WB_BUBBLE;
        end else if (!stall) begin
            slot_q <= next_slot;
        end
    end

    assign write_result   = slot_q.result;
    assign write_addr     = slot_q.addr;
    assign register_write = slot_q.we;

`ifdef WB_RETIRE_COUNT_EN
    // Count every valid slot actually captured; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= 32'd0;
        end else if (!flush && !stall && mem_valid) begin
            retired <= retired + 32'd1;
        end
    end
`endif

endmodule
